rotation_vec_merge: RTL and testbench

- Gathers four consecutive 128-element chunks, each BW_XCOS bits per element, into one 512-element vector.
- Inverse of the rotation-vector split path: the split side streams 128-lane slices indexed by a 2-bit chunk count; this block reassembles the slices in the order chunk 0 to chunk 3.
- Sits at the output of the 128-lane rotation datapath and feeds the full-width descriptor/rotation consumer.
- Double-buffered: an assembly buffer plus an output register, so the next vector can fill while the previous one waits for the consumer.

---
 rtl/rotation_vec_merge.sv | 82 ++++++++
 tb/tb_rotation_vec_merge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotation_vec_merge.sv
// rotation_vec_merge: gathers four consecutive 128-element chunks into one
// 512-element vector. Chunks 0..2 land in an assembly buffer; chunk 3 goes
// together with the buffer straight into the output register. The next
// vector can therefore fill while the previous one waits for the consumer.
module rotation_vec_merge #(
  parameter int BW_XCOS = 10,  // element width, 5 integer bits + fraction
  parameter int CNT_W   = 16   // width of the emitted-vector counter
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic [128*BW_XCOS-1:0] in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [512*BW_XCOS-1:0] out_vec,
  output logic [1:0]             chunk_idx,
  output logic                   sync_err,
  output logic [CNT_W-1:0]       vec_cnt
);

  localparam int CHUNK_W = 128 * BW_XCOS;

  // Slices 0..2 of the vector being assembled; slice 3 never needs storage.
  logic [3*CHUNK_W-1:0] asm_buf;

  logic [1:0] eff_idx;   // slot the chunk on the input takes if accepted
  logic       accept;    // input transfer this cycle
  logic       complete;  // accepted chunk is the last of a vector

  // Handshake decode: only the closing chunk can be refused, and only when
  // the output register is occupied and not being drained this cycle.
  // NOTE: always_comb uses blocking assignments so later lines see the values
  // computed above them; sequential blocks below use non-blocking only.
  always_comb begin
    eff_idx  = in_first ? 2'd0 : chunk_idx;
    in_ready = !((eff_idx == 2'd3) && out_valid && !out_ready);
    accept   = in_valid && in_ready;
    complete = accept && (eff_idx == 2'd3);
  end

  // Assembly side: slice writes, chunk index, resync error pulse.
  // NOTE: the wide assembly buffer is cleared on reset on purpose, so no slice
  // of a vector abandoned by reset can ever be observed afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_buf   <= '0;
      chunk_idx <= 2'd0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= accept && in_first && (chunk_idx != 2'd0);
      if (accept) begin
        // Index 3 wraps to 0 through the 2-bit add.
        chunk_idx <= eff_idx + 2'd1;
        case (eff_idx)
          2'd0:    asm_buf[0         +: CHUNK_W] <= in_vec;
          2'd1:    asm_buf[CHUNK_W   +: CHUNK_W] <= in_vec;
          2'd2:    asm_buf[2*CHUNK_W +: CHUNK_W] <= in_vec;
          default: ;  // last chunk bypasses the buffer into out_vec
        endcase
      end
    end
  end

  // Output register: load on completion (even while the consumer takes the
  // previous vector, giving a bubble-free handoff), clear valid on a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vec   <= '0;
      out_valid <= 1'b0;
      vec_cnt   <= '0;
    end else if (complete) begin
      out_vec   <= {in_vec, asm_buf};
      out_valid <= 1'b1;
      vec_cnt   <= vec_cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotation_vec_merge.sv
// Directed bench for rotation_vec_merge followed by a randomised handshake run
// against a vector-level scoreboard. CNT_W is 4 so the counter wrap is cheap.
module tb_rotation_vec_merge;

  localparam int BW    = 10;
  localparam int CNT_W = 4;
  localparam int CW    = 128 * BW;
  localparam int VW    = 512 * BW;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic [CW-1:0]    in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    out_vec;
  logic [1:0]       chunk_idx;
  logic             sync_err;
  logic [CNT_W-1:0] vec_cnt;

  int total = 0;
  int bad   = 0;

  rotation_vec_merge #(.BW_XCOS(BW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .chunk_idx (chunk_idx),
    .sync_err  (sync_err),
    .vec_cnt   (vec_cnt)
  );

  always #5 clk = ~clk;

  // Chunk with every element equal to v.
  function automatic logic [CW-1:0] fill(input int v);
    logic [CW-1:0] r;
    for (int e = 0; e < 128; e++) r[e*BW +: BW] = BW'(v);
    return r;
  endfunction

  // Vector whose chunk k is filled with the k-th argument.
  function automatic logic [VW-1:0] mkvec(input int a, input int b, input int c, input int d);
    return {fill(d), fill(c), fill(b), fill(a)};
  endfunction

  // Chunk with distinct elements, tagged by a sequence number.
  function automatic logic [CW-1:0] pat(input int s);
    logic [CW-1:0] r;
    for (int e = 0; e < 128; e++) r[e*BW +: BW] = BW'(s * 7 + e);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    int idx;
    idx = -1;
    total++;
    assert (obs === exp) else begin
      bad++;
      for (int e = 0; e < 512; e++) begin
        if (idx < 0 && obs[e*BW +: BW] !== exp[e*BW +: BW]) idx = e;
      end
      $error("FAIL %s: element %0d observed %0h expected %0h", tag, idx,
             obs[idx*BW +: BW], exp[idx*BW +: BW]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic first, input int v);
    in_valid = 1'b1;
    in_first = first;
    in_vec   = fill(v);
    cyc();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  logic [VW-1:0]   q[$];
  logic [3*CW-1:0] mbuf;
  int              mcnt;
  int              seq;
  int              got;
  int              ncyc;
  logic            exp_ready;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check_vec("rst_out_vec", out_vec, '0);
    check("rst_chunk_idx", 64'(chunk_idx), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst = 1'b1;
    cyc();

    // Basic vector: chunk k filled with k+1.
    push(1'b1, 1);
    check("t1_idx1", 64'(chunk_idx), 64'd1);
    check("t1_no_err", 64'(sync_err), 64'd0);
    push(1'b0, 2);
    push(1'b0, 3);
    check("t1_idx3", 64'(chunk_idx), 64'd3);
    check("t1_not_valid", 64'(out_valid), 64'd0);
    push(1'b0, 4);
    check("t1_valid", 64'(out_valid), 64'd1);
    check_vec("t1_vec", out_vec, mkvec(1, 2, 3, 4));
    check("t1_cnt", 64'(vec_cnt), 64'd1);
    check("t1_idx0", 64'(chunk_idx), 64'd0);

    // Back-pressure: second vector stalls on its last chunk.
    out_ready = 1'b0;
    push(1'b1, 5);
    push(1'b0, 6);
    push(1'b0, 7);
    check("t2_held_valid", 64'(out_valid), 64'd1);
    check_vec("t2_held_vec", out_vec, mkvec(1, 2, 3, 4));
    in_valid = 1'b1;
    in_vec   = fill(8);
    #1;
    check("t2_refused", 64'(in_ready), 64'd0);
    cyc();
    check("t2_stall_idx", 64'(chunk_idx), 64'd3);
    check_vec("t2_stall_vec", out_vec, mkvec(1, 2, 3, 4));
    check("t2_stall_cnt", 64'(vec_cnt), 64'd1);
    out_ready = 1'b1;
    #1;
    check("t2_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    check("t2_handoff_valid", 64'(out_valid), 64'd1);
    check_vec("t2_handoff_vec", out_vec, mkvec(5, 6, 7, 8));
    check("t2_cnt", 64'(vec_cnt), 64'd2);
    cyc();
    check("t2_drained", 64'(out_valid), 64'd0);
    check_vec("t2_vec_holds", out_vec, mkvec(5, 6, 7, 8));

    // Resynchronisation after two chunks.
    push(1'b1, 9);
    push(1'b0, 10);
    check("t3_idx2", 64'(chunk_idx), 64'd2);
    push(1'b1, 11);
    check("t3_sync_err", 64'(sync_err), 64'd1);
    check("t3_idx1", 64'(chunk_idx), 64'd1);
    check("t3_no_vec", 64'(out_valid), 64'd0);
    cyc();
    check("t3_err_pulse", 64'(sync_err), 64'd0);
    push(1'b0, 12);
    push(1'b0, 13);
    push(1'b0, 14);
    check("t3_valid", 64'(out_valid), 64'd1);
    check_vec("t3_vec", out_vec, mkvec(11, 12, 13, 14));
    check("t3_cnt", 64'(vec_cnt), 64'd3);
    cyc();

    // Asynchronous reset mid-vector.
    push(1'b1, 15);
    push(1'b0, 16);
    push(1'b0, 17);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t4_valid", 64'(out_valid), 64'd0);
    check_vec("t4_vec", out_vec, '0);
    check("t4_idx", 64'(chunk_idx), 64'd0);
    check("t4_cnt", 64'(vec_cnt), 64'd0);
    check("t4_err", 64'(sync_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    push(1'b0, 18);
    push(1'b0, 19);
    push(1'b0, 20);
    check("t4_partial_no_vec", 64'(out_valid), 64'd0);
    push(1'b0, 21);
    check("t4_valid_after", 64'(out_valid), 64'd1);
    check_vec("t4_vec_after", out_vec, mkvec(18, 19, 20, 21));
    check("t4_cnt_after", 64'(vec_cnt), 64'd1);
    cyc();
    check("t4_single_vec", 64'(out_valid), 64'd0);

    // Counter wrap: 15 more vectors bring the 4-bit count back to 0.
    for (int i = 0; i < 15; i++) begin
      if (i == 14) check("t5_cnt15", 64'(vec_cnt), 64'd15);
      push(1'b1, 100 + i * 4);
      push(1'b0, 101 + i * 4);
      push(1'b0, 102 + i * 4);
      push(1'b0, 103 + i * 4);
    end
    check("t5_wrap", 64'(vec_cnt), 64'd0);
    check_vec("t5_vec", out_vec, mkvec(156, 157, 158, 159));
    cyc();
    check("t5_drained", 64'(out_valid), 64'd0);

    // Random valid/ready traffic against a vector scoreboard.
    mcnt = 0;
    seq  = 0;
    got  = 0;
    ncyc = 0;
    mbuf = '0;
    while (got < 1000 && ncyc < 40000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_first  = 1'b0;
      in_vec    = pat(seq);
      #1;
      exp_ready = !((mcnt == 3) && (q.size() != 0) && !out_ready);
      check("rand_in_ready", 64'(in_ready), 64'(exp_ready));
      check("rand_out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && out_ready && q.size() != 0) begin
        check_vec("rand_vec", out_vec, q[0]);
        void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        if (mcnt == 3) begin
          q.push_back({pat(seq), mbuf});
          mcnt = 0;
        end else begin
          mbuf[mcnt*CW +: CW] = pat(seq);
          mcnt++;
        end
        seq++;
      end
      cyc();
      ncyc++;
    end
    in_valid = 1'b0;
    check("rand_received", 64'(got), 64'd1000);
    check("rand_idx", 64'(chunk_idx), 64'(mcnt));
    check("rand_cnt", 64'(vec_cnt), 64'((got + q.size()) % 16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
